id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline register with load-use hazard detection and bubble insertion for the five-stage pipelined MIPS CPU. It sits between the Reg/Dec (ID) unit and the EX stage. It latches decoded operands and control each cycle, and detects a load followed by a dependent instruction. On such a hazard it holds the IF/ID register and PC through its `stall_ifid` output and injects a one-cycle bubble into EX. It also supports branch flush, external hold and a saturating bubble counter for performance monitoring.

## Interface
Parameters:
- `CTRL_W`, 16: width of the packed EX/MEM/WB control bundle from the ID control unit.
- `CNT_W`, 16: width of the bubble counter.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `id_valid`  in  1  ID holds a real instruction.
- `flush`  in  1  taken branch/jump resolved downstream; squash the ID instruction.
- `hold`  in  1  external pipeline freeze, e.g. memory busy.
- `pc_id`, `busA_id`, `busB_id`, `imm32_id`  in  32 each  PC and decoded operands.
- `shamt_id`  in  5  shift amount.
- `rs_id`, `rt_id`, `rd_id`  in  5 each  register specifiers.
- `uses_rs`, `uses_rt`  in  1 each  the ID instruction reads Rs / Rt.
- `mem_read_id`  in  1  the ID instruction is a load.
- `ctrl_id`  in  CTRL_W  control bundle.
- `ex_valid`  out  1  EX holds a real instruction.
- `pc_ex`, `busA_ex`, `busB_ex`, `imm32_ex`  out  32 each  registered copies of the ID inputs.
- `shamt_ex`, `rs_ex`, `rt_ex`, `rd_ex`  out  5 each  registered copies of the ID inputs.
- `mem_read_ex`  out  1  registered copy of `mem_read_id`.
- `ctrl_ex`  out  CTRL_W  registered copy of `ctrl_id`.
- `stall_ifid`  out  1  combinational; holds IF/ID and the PC.
- `bubble_cnt`  out  CNT_W  count of load-use bubbles inserted.

## Operation
Hazard term, combinational from the registered EX state:
- `lu = ex_valid & mem_read_ex & (rt_ex != 0) & id_valid & ((uses_rs & rs_id == rt_ex) | (uses_rt & rt_id == rt_ex))`.

Per-cycle action, highest priority first:
1. `rst` low: all registered outputs go to 0 asynchronously, `bubble_cnt` = 0, so EX holds a bubble.
2. `flush`: load a bubble: `ex_valid` = 0, `ctrl_ex` = 0, `mem_read_ex` = 0, data fields = 0. `stall_ifid` = 0, because the IF/ID flush is handled by the branch logic.
3. `hold`: all ID/EX registers keep their value. `stall_ifid` = 1. The counter is unchanged.
4. `lu`: load a bubble as in step 2. `stall_ifid` = 1. `bubble_cnt` increments, saturating at all-ones.
5. Otherwise: load every `_id` input into the matching `_ex` output. `ex_valid` = `id_valid`. `stall_ifid` = 0.

Further rules:
- A bubble always forces `ctrl_ex` = 0. An all-zero bundle therefore means no register write, no memory write and no branch.
- `stall_ifid` = `~flush & (hold | lu)`.
- Register 0 never creates a hazard.

## Timing
- Latency is 1 cycle from ID inputs to `_ex` outputs.
- A load-use stall lasts exactly 1 cycle. In the next cycle EX holds the bubble, so `lu` = 0 and the held ID instruction advances.
- `flush` in the same cycle as `lu` or `hold`: flush wins. No stall is raised and the counter does not increment.
- `hold` in the same cycle as `lu`: hold wins. The load stays in EX and `lu` is re-evaluated on the next cycle.
- Back-to-back loads with a dependency chain (lw r2; lw r3,0(r2)): one bubble. The second load then becomes the EX load for the next comparison.
- Reset asserted mid-stall: outputs clear immediately. After release the ID instruction proceeds without a stall.

## Structure
- Shared package `cpu_pkg` holds `CTRL_W` and the bit positions of the control bundle (`RegWr`, `MemWr`, `MemtoReg`, `ALUSrc`, `RegDst`, `Branch`, `Jump`, `Jal`, `ALUctr`). It also holds the bubble constant.
- One sub-module is natural: `load_use_detect`, which is purely combinational and produces `lu`. The register bank and counter live in `id_ex_stage`.

## Test plan
- Reset: release `rst` and check all `_ex` outputs are 0, `ex_valid` = 0 and `bubble_cnt` = 0. Then feed `addu r3,r1,r2` with `pc_id` = 0x0000_0004 and check `pc_ex` = 0x0000_0004 and `ex_valid` = 1 one cycle later.
- Load-use: `lw r2,0(r1)` followed by `addu r4,r2,r5`. Check `stall_ifid` = 1 for exactly 1 cycle, then EX shows a bubble (`ex_valid` = 0, `ctrl_ex` = 0), then the add. `bubble_cnt` = 1.
- No false hazard: `lw r0,0(r1)` followed by a reader of r0 gives no stall. `lw r2` followed by `j`, with `uses_rs` = `uses_rt` = 0, gives no stall.
- Flush during hazard: `flush` = 1 in the `lu` cycle. Check `stall_ifid` = 0, a bubble is loaded and `bubble_cnt` is unchanged.
- Hold: `hold` = 1 for 3 cycles with the ID inputs changing. Check the `_ex` outputs stay frozen, `stall_ifid` = 1 throughout, then resume loading.
- Saturation: with `CNT_W` = 4, apply 17 load-use pairs. Check `bubble_cnt` = 15.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: control-bundle bit positions, the ID/EX data
// record and the bubble constant.
package cpu_pkg;

  localparam int unsigned CTRL_W = 16;

  localparam int unsigned CTRL_REGWR      = 0;
  localparam int unsigned CTRL_MEMWR      = 1;
  localparam int unsigned CTRL_MEMTOREG   = 2;
  localparam int unsigned CTRL_ALUSRC     = 3;
  localparam int unsigned CTRL_REGDST     = 4;
  localparam int unsigned CTRL_BRANCH     = 5;
  localparam int unsigned CTRL_JUMP       = 6;
  localparam int unsigned CTRL_JAL        = 7;
  localparam int unsigned CTRL_ALUCTR_LSB = 8;
  localparam int unsigned CTRL_ALUCTR_W   = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] busA;
    logic [31:0] busB;
    logic [31:0] imm32;
    logic [4:0]  shamt;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        mem_read;
  } ex_data_t;

  localparam ex_data_t EX_DATA_BUBBLE = '0;

  typedef enum logic [1:0] {
    ACT_LOAD,
    ACT_FLUSH,
    ACT_HOLD,
    ACT_STALL
  } stage_act_e;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard: a load in EX whose destination is read by the ID instruction.
module load_use_detect (
  input  logic       ex_valid_i,
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rt_i,
  input  logic       id_valid_i,
  input  logic       uses_rs_i,
  input  logic       uses_rt_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  output logic       lu_o
);

  logic rs_hit;
  logic rt_hit;

  always_comb begin
    rs_hit = uses_rs_i && (id_rs_i == ex_rt_i);
    rt_hit = uses_rt_i && (id_rt_i == ex_rt_i);
    // r0 is hard-wired zero, so a load into it never produces a dependency
    lu_o   = ex_valid_i && ex_mem_read_i && (ex_rt_i != '0) && id_valid_i && (rs_hit || rt_hit);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, bubble insertion, branch flush,
// external hold and a saturating bubble counter.
module id_ex_stage #(
  parameter int unsigned CTRL_W = cpu_pkg::CTRL_W,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              flush,
  input  logic              hold,
  input  logic [31:0]       pc_id,
  input  logic [31:0]       busA_id,
  input  logic [31:0]       busB_id,
  input  logic [31:0]       imm32_id,
  input  logic [4:0]        shamt_id,
  input  logic [4:0]        rs_id,
  input  logic [4:0]        rt_id,
  input  logic [4:0]        rd_id,
  input  logic              uses_rs,
  input  logic              uses_rt,
  input  logic              mem_read_id,
  input  logic [CTRL_W-1:0] ctrl_id,
  output logic              ex_valid,
  output logic [31:0]       pc_ex,
  output logic [31:0]       busA_ex,
  output logic [31:0]       busB_ex,
  output logic [31:0]       imm32_ex,
  output logic [4:0]        shamt_ex,
  output logic [4:0]        rs_ex,
  output logic [4:0]        rt_ex,
  output logic [4:0]        rd_ex,
  output logic              mem_read_ex,
  output logic [CTRL_W-1:0] ctrl_ex,
  output logic              stall_ifid,
  output logic [CNT_W-1:0]  bubble_cnt
);

  import cpu_pkg::*;

  ex_data_t          data_id, data_d, data_q;
  logic              valid_d, valid_q;
  logic [CTRL_W-1:0] ctrl_d, ctrl_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic              lu;
  stage_act_e        act;

  always_comb begin
    data_id = '{pc: pc_id, busA: busA_id, busB: busB_id, imm32: imm32_id,
                shamt: shamt_id, rs: rs_id, rt: rt_id, rd: rd_id,
                mem_read: mem_read_id};
  end

  load_use_detect u_load_use_detect (
    .ex_valid_i    (valid_q),
    .ex_mem_read_i (data_q.mem_read),
    .ex_rt_i       (data_q.rt),
    .id_valid_i    (id_valid),
    .uses_rs_i     (uses_rs),
    .uses_rt_i     (uses_rt),
    .id_rs_i       (rs_id),
    .id_rt_i       (rt_id),
    .lu_o          (lu)
  );

  // Priority: flush beats hold beats load-use
  always_comb begin
    act = ACT_LOAD;
    if (flush)     act = ACT_FLUSH;
    else if (hold) act = ACT_HOLD;
    else if (lu)   act = ACT_STALL;
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    cnt_d   = cnt_q;
    case (act)
      ACT_LOAD: begin
        data_d  = data_id;
        valid_d = id_valid;
        ctrl_d  = ctrl_id;
      end
      ACT_FLUSH, ACT_STALL: begin
        data_d  = EX_DATA_BUBBLE;
        valid_d = 1'b0;
        ctrl_d  = '0;
      end
      default: ;
    endcase
    if (act == ACT_STALL && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q  <= EX_DATA_BUBBLE;
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      cnt_q   <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall_ifid  = (act == ACT_HOLD) || (act == ACT_STALL);
  assign ex_valid    = valid_q;
  assign pc_ex       = data_q.pc;
  assign busA_ex     = data_q.busA;
  assign busB_ex     = data_q.busB;
  assign imm32_ex    = data_q.imm32;
  assign shamt_ex    = data_q.shamt;
  assign rs_ex       = data_q.rs;
  assign rt_ex       = data_q.rt;
  assign rd_ex       = data_q.rd;
  assign mem_read_ex = data_q.mem_read;
  assign ctrl_ex     = ctrl_q;
  assign bubble_cnt  = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed instruction stream, expected EX
// state queued per cycle and checked by an independent monitor.
module tb_id_ex_stage;

  localparam logic [15:0] C_ADDU = 16'h0111;
  localparam logic [15:0] C_LW   = 16'h000D;
  localparam logic [15:0] C_J    = 16'h0040;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, flush, hold;
  logic [31:0] pc_id, busA_id, busB_id, imm32_id;
  logic [4:0]  shamt_id, rs_id, rt_id, rd_id;
  logic        uses_rs, uses_rt, mem_read_id;
  logic [15:0] ctrl_id;
  logic        ex_valid;
  logic [31:0] pc_ex, busA_ex, busB_ex, imm32_ex;
  logic [4:0]  shamt_ex, rs_ex, rt_ex, rd_ex;
  logic        mem_read_ex;
  logic [15:0] ctrl_ex;
  logic        stall_ifid;
  logic [3:0]  bubble_cnt;

  always #5 clk = ~clk;

  id_ex_stage #(.CTRL_W(16), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .flush(flush), .hold(hold),
    .pc_id(pc_id), .busA_id(busA_id), .busB_id(busB_id), .imm32_id(imm32_id),
    .shamt_id(shamt_id), .rs_id(rs_id), .rt_id(rt_id), .rd_id(rd_id),
    .uses_rs(uses_rs), .uses_rt(uses_rt), .mem_read_id(mem_read_id), .ctrl_id(ctrl_id),
    .ex_valid(ex_valid), .pc_ex(pc_ex), .busA_ex(busA_ex), .busB_ex(busB_ex),
    .imm32_ex(imm32_ex), .shamt_ex(shamt_ex), .rs_ex(rs_ex), .rt_ex(rt_ex),
    .rd_ex(rd_ex), .mem_read_ex(mem_read_ex), .ctrl_ex(ctrl_ex),
    .stall_ifid(stall_ifid), .bubble_cnt(bubble_cnt)
  );

  typedef struct {
    logic        stall;
    logic        val;
    logic        mr;
    logic [31:0] pc;
    logic [15:0] ctrl;
    logic [4:0]  rt;
    logic [3:0]  cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Operand fields are derived from the PC so a frozen or bubbled EX stage is visible
  function automatic logic [31:0] f_busA(input logic [31:0] pc);
    return (pc == 32'h0) ? 32'h0 : (pc ^ 32'hA5A5_0000);
  endfunction
  function automatic logic [31:0] f_busB(input logic [31:0] pc);
    return (pc == 32'h0) ? 32'h0 : (pc ^ 32'h5A5A_0000);
  endfunction
  function automatic logic [31:0] f_imm(input logic [31:0] pc);
    return (pc == 32'h0) ? 32'h0 : {pc[29:0], 2'b11};
  endfunction
  function automatic logic [4:0] f_shamt(input logic [31:0] pc);
    return (pc == 32'h0) ? 5'h0 : pc[6:2];
  endfunction
  function automatic logic [4:0] f_rd(input logic [31:0] pc);
    return (pc == 32'h0) ? 5'h0 : (pc[6:2] ^ 5'h1F);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    id_valid = 0; flush = 0; hold = 0;
    pc_id = '0; busA_id = '0; busB_id = '0; imm32_id = '0;
    shamt_id = '0; rs_id = '0; rt_id = '0; rd_id = '0;
    uses_rs = 0; uses_rt = 0; mem_read_id = 0; ctrl_id = '0;
  endtask

  task automatic step(input logic idv, input logic fl, input logic hd, input logic [31:0] pc,
                      input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
                      input logic mr, input logic [15:0] ctrl,
                      input logic e_stall, input logic e_val, input logic [31:0] e_pc,
                      input logic [15:0] e_ctrl, input logic [4:0] e_rt, input logic e_mr,
                      input logic [3:0] e_cnt);
    exp_t e;
    @(negedge clk);
    id_valid = idv; flush = fl; hold = hd;
    pc_id = pc; busA_id = f_busA(pc); busB_id = f_busB(pc); imm32_id = f_imm(pc);
    shamt_id = f_shamt(pc); rd_id = f_rd(pc); rs_id = rs; rt_id = rt;
    uses_rs = urs; uses_rt = urt; mem_read_id = mr; ctrl_id = ctrl;
    e.stall = e_stall; e.val = e_val; e.mr = e_mr; e.pc = e_pc;
    e.ctrl = e_ctrl; e.rt = e_rt; e.cnt = e_cnt;
    sb.push_back(e);
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
    #2;
    chk("scoreboard_drained", sb.size(), 0);
    @(negedge clk);
  endtask

  // Monitor: stall is sampled just before the edge, EX state just after it
  initial begin
    exp_t e;
    logic s;
    forever begin
      @(negedge clk);
      #4;
      if (sb.size() != 0) begin
        s = stall_ifid;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("stall_ifid", {31'b0, s}, {31'b0, e.stall});
        chk("ex_valid", {31'b0, ex_valid}, {31'b0, e.val});
        chk("pc_ex", pc_ex, e.pc);
        chk("ctrl_ex", {16'b0, ctrl_ex}, {16'b0, e.ctrl});
        chk("rt_ex", {27'b0, rt_ex}, {27'b0, e.rt});
        chk("mem_read_ex", {31'b0, mem_read_ex}, {31'b0, e.mr});
        chk("busA_ex", busA_ex, f_busA(e.pc));
        chk("busB_ex", busB_ex, f_busB(e.pc));
        chk("imm32_ex", imm32_ex, f_imm(e.pc));
        chk("shamt_ex", {27'b0, shamt_ex}, {27'b0, f_shamt(e.pc)});
        chk("rd_ex", {27'b0, rd_ex}, {27'b0, f_rd(e.pc)});
        chk("bubble_cnt", {28'b0, bubble_cnt}, {28'b0, e.cnt});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned c_prev;
    int unsigned c_now;
    rst = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    chk("rst_ex_valid", {31'b0, ex_valid}, 32'h0);
    chk("rst_pc_ex", pc_ex, 32'h0);
    chk("rst_busA_ex", busA_ex, 32'h0);
    chk("rst_ctrl_ex", {16'b0, ctrl_ex}, 32'h0);
    chk("rst_mem_read_ex", {31'b0, mem_read_ex}, 32'h0);
    chk("rst_bubble_cnt", {28'b0, bubble_cnt}, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_ex_valid", {31'b0, ex_valid}, 32'h0);
    chk("post_rst_stall", {31'b0, stall_ifid}, 32'h0);

    //   idv fl hd pc        rs    rt    urs urt mr ctrl     | stall val pc      ctrl    rt    mr cnt
    step(1, 0, 0, 32'h04, 5'd1, 5'd2, 1, 1, 0, C_ADDU,   0, 1, 32'h04, C_ADDU, 5'd2, 0, 4'd0);
    step(1, 0, 0, 32'h08, 5'd1, 5'd2, 1, 0, 1, C_LW,     0, 1, 32'h08, C_LW,   5'd2, 1, 4'd0);
    step(1, 0, 0, 32'h0C, 5'd2, 5'd5, 1, 1, 0, C_ADDU,   1, 0, 32'h00, 16'h0,  5'd0, 0, 4'd1);
    step(1, 0, 0, 32'h0C, 5'd2, 5'd5, 1, 1, 0, C_ADDU,   0, 1, 32'h0C, C_ADDU, 5'd5, 0, 4'd1);
    // load into r0 followed by a reader of r0
    step(1, 0, 0, 32'h10, 5'd1, 5'd0, 1, 0, 1, C_LW,     0, 1, 32'h10, C_LW,   5'd0, 1, 4'd1);
    step(1, 0, 0, 32'h14, 5'd0, 5'd0, 1, 1, 0, C_ADDU,   0, 1, 32'h14, C_ADDU, 5'd0, 0, 4'd1);
    // load followed by a jump whose field bits alias r2 but reads nothing
    step(1, 0, 0, 32'h18, 5'd1, 5'd2, 1, 0, 1, C_LW,     0, 1, 32'h18, C_LW,   5'd2, 1, 4'd1);
    step(1, 0, 0, 32'h1C, 5'd2, 5'd2, 0, 0, 0, C_J,      0, 1, 32'h1C, C_J,    5'd2, 0, 4'd1);
    // flush in the hazard cycle
    step(1, 0, 0, 32'h20, 5'd1, 5'd2, 1, 0, 1, C_LW,     0, 1, 32'h20, C_LW,   5'd2, 1, 4'd1);
    step(1, 1, 0, 32'h24, 5'd5, 5'd2, 1, 1, 0, C_ADDU,   0, 0, 32'h00, 16'h0,  5'd0, 0, 4'd1);
    // dependent load chain
    step(1, 0, 0, 32'h28, 5'd1, 5'd3, 1, 0, 1, C_LW,     0, 1, 32'h28, C_LW,   5'd3, 1, 4'd1);
    step(1, 0, 0, 32'h2C, 5'd3, 5'd7, 1, 0, 1, C_LW,     1, 0, 32'h00, 16'h0,  5'd0, 0, 4'd2);
    step(1, 0, 0, 32'h2C, 5'd3, 5'd7, 1, 0, 1, C_LW,     0, 1, 32'h2C, C_LW,   5'd7, 1, 4'd2);
    // hold for three cycles, overlapping a pending hazard, ID inputs changing
    step(1, 0, 1, 32'h30, 5'd7, 5'd1, 1, 1, 0, C_ADDU,   1, 1, 32'h2C, C_LW,   5'd7, 1, 4'd2);
    step(1, 0, 1, 32'h34, 5'd9, 5'd9, 1, 1, 0, C_ADDU,   1, 1, 32'h2C, C_LW,   5'd7, 1, 4'd2);
    step(1, 0, 1, 32'h38, 5'd1, 5'd6, 1, 1, 1, C_LW,     1, 1, 32'h2C, C_LW,   5'd7, 1, 4'd2);
    step(1, 0, 0, 32'h30, 5'd7, 5'd1, 1, 1, 0, C_ADDU,   1, 0, 32'h00, 16'h0,  5'd0, 0, 4'd3);
    step(1, 0, 0, 32'h30, 5'd7, 5'd1, 1, 1, 0, C_ADDU,   0, 1, 32'h30, C_ADDU, 5'd1, 0, 4'd3);
    step(1, 0, 0, 32'h40, 5'd1, 5'd2, 1, 0, 1, C_LW,     0, 1, 32'h40, C_LW,   5'd2, 1, 4'd3);
    drain();

    // reset asserted while a load-use stall is pending
    id_valid = 1; pc_id = 32'h44; busA_id = f_busA(32'h44); busB_id = f_busB(32'h44);
    imm32_id = f_imm(32'h44); shamt_id = f_shamt(32'h44); rd_id = f_rd(32'h44);
    rs_id = 5'd2; rt_id = 5'd5; uses_rs = 1; uses_rt = 1; mem_read_id = 0; ctrl_id = C_ADDU;
    #1;
    chk("pre_reset_stall", {31'b0, stall_ifid}, 32'h1);
    rst = 1'b0;
    #1;
    chk("mid_reset_ex_valid", {31'b0, ex_valid}, 32'h0);
    chk("mid_reset_pc_ex", pc_ex, 32'h0);
    chk("mid_reset_cnt", {28'b0, bubble_cnt}, 32'h0);
    chk("mid_reset_stall", {31'b0, stall_ifid}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    step(1, 0, 0, 32'h44, 5'd2, 5'd5, 1, 1, 0, C_ADDU,   0, 1, 32'h44, C_ADDU, 5'd5, 0, 4'd0);

    // 17 load-use pairs against a 4-bit counter
    for (int i = 1; i <= 17; i++) begin
      c_prev = (i - 1 < 15) ? i - 1 : 15;
      c_now  = (i < 15) ? i : 15;
      step(1, 0, 0, 32'h100, 5'd1, 5'd2, 1, 0, 1, C_LW,   0, 1, 32'h100, C_LW,   5'd2, 1, 4'(c_prev));
      step(1, 0, 0, 32'h104, 5'd2, 5'd5, 1, 1, 0, C_ADDU, 1, 0, 32'h000, 16'h0,  5'd0, 0, 4'(c_now));
      step(1, 0, 0, 32'h104, 5'd2, 5'd5, 1, 1, 0, C_ADDU, 0, 1, 32'h104, C_ADDU, 5'd5, 0, 4'(c_now));
    end
    drain();
    chk("bubble_cnt_saturated", {28'b0, bubble_cnt}, 32'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
